// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between a CPU port and a debug/loader port.
// One transaction at a time: IDLE picks a winner and latches its command,
// ACCESS issues exactly one RAM strobe, CAPTURE (reads only) registers the
// RAM data, DONE pulses the winner's done and returns to IDLE.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// in favour of the port not served last; otherwise the CPU always wins ties.
//
// Handshake: a port raises *_req with *_we/*_addr/*_wdata valid and keeps it
// high until *_done pulses for one cycle. The command is captured on the edge
// that samples *_req in IDLE and later changes are ignored. *_gnt is high from
// ACCESS through DONE. Dropping *_req after capture does not cancel the access.
//
// o_fsm_state exposes the controller state (IDLE=0, ACCESS=1, CAPTURE=2, DONE=3).

module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [8:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [8:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_any_req;
  logic        w_pick_dbg;

  // Latched command of the current winner.
  logic        r_sel_dbg;
  logic        r_we;
  logic [8:0]  r_addr;
  logic [31:0] r_wdata;

  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dbg_rdata;

  assign w_any_req = cpu_req | dbg_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last-served pointer: 1 = debug port was served last. Resets to debug so
  // the CPU wins the first tie.
  logic r_last_dbg;

  assign w_pick_dbg = dbg_req & (~cpu_req | ~r_last_dbg);

  // Record who was served when each transaction completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_dbg <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_last_dbg <= r_sel_dbg;
    end
  end
`else
  // Fixed priority: debug only wins when the CPU is not asking.
  assign w_pick_dbg = dbg_req & ~cpu_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the winner's command when a transaction starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_dbg <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_sel_dbg <= w_pick_dbg;
      r_we      <= w_pick_dbg ? dbg_we    : cpu_we;
      r_addr    <= w_pick_dbg ? dbg_addr  : cpu_addr;
      r_wdata   <= w_pick_dbg ? dbg_wdata : cpu_wdata;
    end
  end

  // Register RAM read data into the winner's result; the other port holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else if (r_state == S_CAPTURE) begin
      if (r_sel_dbg) begin
        r_dbg_rdata <= mem_rdata;
      end else begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    cpu_gnt     = 1'b0;
    cpu_done    = 1'b0;
    dbg_gnt     = 1'b0;
    dbg_done    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cpu_gnt     = ~r_sel_dbg;
        dbg_gnt     = r_sel_dbg;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        mem_we      = r_we;
        mem_re      = ~r_we;
        w_state_nxt = r_we ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        cpu_gnt     = ~r_sel_dbg;
        dbg_gnt     = r_sel_dbg;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        cpu_gnt     = ~r_sel_dbg;
        dbg_gnt     = r_sel_dbg;
        cpu_done    = ~r_sel_dbg;
        dbg_done    = r_sel_dbg;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cpu_rdata   = r_cpu_rdata;
  assign dbg_rdata   = r_dbg_rdata;
  assign o_fsm_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbiter and a shadow copy of RAM contents.
// Define MEM_ARB_ROUND_ROBIN_EN for both bench and RTL to test that build.

module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_done;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [8:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_done;
  logic [31:0] dbg_rdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;
  logic [1:0]  o_fsm_state;

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .o_fsm_state(o_fsm_state)
  );

  // ---------------- RAM behind the arbiter ----------------
  // Read data appears the cycle after mem_re; other cycles carry junk so a
  // capture on the wrong cycle shows up.
  logic [31:0] ram [512];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
    else        mem_rdata <= $urandom;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction occupies cycles 1..L after the edge that accepted it
  // (L = 2 for a write, 3 for a read). Cycle 1 carries the RAM strobe, the
  // last cycle carries done, and a read's data lands at the end of cycle 2.
  bit          m_busy = 1'b0;
  int          m_pos = 0;
  bit          m_win_dbg = 1'b0;
  bit          m_we = 1'b0;
  logic [8:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata [2];
  logic [31:0] exp_mem [512];
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit          m_last_dbg = 1'b1;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_pos = 0;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_last_dbg = 1'b1;
`endif
    end else if (m_busy) begin
      if (m_we && m_pos == 1) exp_mem[m_addr] = m_wdata;
      if (!m_we && m_pos == 2) m_rdata[m_win_dbg] = exp_mem[m_addr];
      if (m_pos == (m_we ? 2 : 3)) begin
        m_busy = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_last_dbg = m_win_dbg;
`endif
      end else begin
        m_pos++;
      end
    end else if (cpu_req || dbg_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (cpu_req && dbg_req) m_win_dbg = !m_last_dbg;
      else                    m_win_dbg = dbg_req;
`else
      m_win_dbg = dbg_req && !cpu_req;
`endif
      m_we    = m_win_dbg ? dbg_we    : cpu_we;
      m_addr  = m_win_dbg ? dbg_addr  : cpu_addr;
      m_wdata = m_win_dbg ? dbg_wdata : cpu_wdata;
      m_busy  = 1'b1;
      m_pos   = 1;
    end
  end

  // Compare every DUT output with the model on each falling edge.
  bit          e_acc, e_last;
  always @(negedge clk) begin
    e_acc  = m_busy && (m_pos == 1);
    e_last = m_busy && (m_pos == (m_we ? 2 : 3));
    check("m_cpu_gnt",   32'(cpu_gnt),   32'(m_busy && !m_win_dbg));
    check("m_dbg_gnt",   32'(dbg_gnt),   32'(m_busy && m_win_dbg));
    check("m_cpu_done",  32'(cpu_done),  32'(e_last && !m_win_dbg));
    check("m_dbg_done",  32'(dbg_done),  32'(e_last && m_win_dbg));
    check("m_mem_we",    32'(mem_we),    32'(e_acc && m_we));
    check("m_mem_re",    32'(mem_re),    32'(e_acc && !m_we));
    check("m_mem_addr",  32'(mem_addr),  e_acc ? 32'(m_addr) : 32'd0);
    check("m_mem_wdata", mem_wdata,      e_acc ? m_wdata : 32'd0);
    check("m_cpu_rdata", cpu_rdata,      m_rdata[0]);
    check("m_dbg_rdata", dbg_rdata,      m_rdata[1]);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_we, mem_re}), 32'd0);
    check({tag, "_state"}, 32'(o_fsm_state), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
  endtask

  task automatic wait_done(input bit on_dbg, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (on_dbg ? dbg_done : cpu_done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic rand_port(input bit done_seen, inout logic req, inout logic we,
                           inout logic [8:0] addr, inout logic [31:0] wdata);
    int a;
    if (req && !done_seen) begin
      if ($urandom_range(0, 15) == 0) req = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        we = 1'($urandom_range(0, 1));
        addr = 9'($urandom_range(0, 511));
        wdata = $urandom;
      end
    end else begin
      req = done_seen ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 9);
      addr = (a < 8) ? 9'(a) : ((a == 8) ? 9'h1FF : 9'($urandom_range(0, 511)));
      we = 1'($urandom_range(0, 1));
      wdata = $urandom;
    end
  endtask

  // ---------------- stimulus ----------------
  bit ok;
  int cnt;
  bit cd, dd;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = $urandom;
      exp_mem[i] = ram[i];
    end

    // Reset state.
    repeat (3) sample();
    check_all_zero("rst");
    tick();
    reset_n = 1'b1;

    // CPU write 0x010 <- 0xDEADBEEF.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'hDEADBEEF;
    sample();
    check("w_idle_gnt", 32'(cpu_gnt), 32'd0);
    sample();
    check("w_acc_we", 32'(mem_we), 32'd1);
    check("w_acc_addr", 32'(mem_addr), 32'h010);
    check("w_acc_wdata", mem_wdata, 32'hDEADBEEF);
    check("w_acc_done", 32'(cpu_done), 32'd0);
    sample();
    check("w_done", 32'(cpu_done), 32'd1);
    check("w_done_we", 32'(mem_we), 32'd0);
    tick();
    cpu_req = 1'b0;
    sample();
    check("w_after_done", 32'(cpu_done), 32'd0);

    // Debug read 0x010 returns the value just written.
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
    sample();
    sample();
    check("r_acc_re", 32'(mem_re), 32'd1);
    check("r_acc_gnt", 32'({cpu_gnt, dbg_gnt}), 32'b01);
    sample();
    check("r_cap_done", 32'(dbg_done), 32'd0);
    sample();
    check("r_done", 32'(dbg_done), 32'd1);
    check("r_rdata", dbg_rdata, 32'hDEADBEEF);
    check("r_cpu_rdata", cpu_rdata, 32'd0);
    tick();
    dbg_req = 1'b0;
    sample();
    check("r_hold", dbg_rdata, 32'hDEADBEEF);

    // CPU write to 0x1FF with req dropped during ACCESS.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h1FF; cpu_wdata = 32'h12345678;
    sample();
    tick();
    cpu_req = 1'b0; cpu_addr = 9'h000; cpu_wdata = 32'h0;
    sample();
    check("d_acc_we", 32'(mem_we), 32'd1);
    check("d_acc_addr", 32'(mem_addr), 32'h1FF);
    check("d_acc_wdata", mem_wdata, 32'h12345678);
    sample();
    check("d_done", 32'(cpu_done), 32'd1);
    cnt = 0;
    repeat (6) begin sample(); if (cpu_done) cnt++; end
    check("d_single_done", 32'(cnt), 32'd0);

    // Back-to-back reads of 0x1FF: one IDLE cycle between done and ACCESS.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1FF;
    wait_done(1'b0, ok);
    check("b_first_done", 32'(ok), 32'd1);
    check("b_rdata", cpu_rdata, 32'h12345678);
    sample();
    check("b_gap", 32'({cpu_gnt, mem_re}), 32'd0);
    sample();
    check("b_second_acc", 32'({cpu_gnt, mem_re}), 32'b11);
    check("b_second_addr", 32'(mem_addr), 32'h1FF);
    tick();
    cpu_req = 1'b0;
    wait_done(1'b0, ok);
    check("b_second_done", 32'(ok), 32'd1);

    // Reset asserted during CAPTURE of a CPU read.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
    sample();
    sample();
    check("x_acc_re", 32'(mem_re), 32'd1);
    tick();
    cpu_req = 1'b0;
    sample();
    check("x_cap", 32'({cpu_gnt, cpu_done}), 32'b10);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("x_async");
    sample();
    check_all_zero("x_next");
    tick();
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin sample(); if (cpu_done) cnt++; end
    check("x_no_done", 32'(cnt), 32'd0);

    // Both ports requesting continuously for four transactions.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
`endif
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h020; cpu_wdata = 32'hC0C0C0C0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h021; dbg_wdata = 32'hD0D0D0D0;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      sample();
      if (cpu_done || dbg_done) begin
        check("t_order", 32'(dbg_done), 32'(exp_q.pop_front()));
        cnt++;
      end
    end
    check("t_count", 32'(cnt), 32'd4);
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (4) sample();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      sample();
      cd = cpu_done;
      dd = dbg_done;
      tick();
      reset_n = ($urandom_range(0, 499) != 0);
      rand_port(cd, cpu_req, cpu_we, cpu_addr, cpu_wdata);
      rand_port(dd, dbg_req, dbg_we, dbg_addr, dbg_wdata);
    end

    tick();
    reset_n = 1'b1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (6) sample();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port cpu_req, input, 1: CPU access request, held until cpu_done.
REQ-004 SHALL have port cpu_we, input, 1: 1 = write, 0 = read.
REQ-005 SHALL have port cpu_addr, input, 9: CPU word address.
REQ-006 SHALL have port cpu_wdata, input, 32: CPU write data.
REQ-007 SHALL have port cpu_gnt, output, 1: CPU owns memory.
REQ-008 SHALL have port cpu_done, output, 1: one-cycle CPU completion pulse.
REQ-009 SHALL have port cpu_rdata, output, 32: CPU read result.
REQ-010 SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata: debug/loader port, same directions, widths and meanings as the cpu_* ports.
REQ-011 SHALL have port mem_addr, output, 9: RAM address.
REQ-012 SHALL have port mem_wdata, output, 32: RAM write data.
REQ-013 SHALL have port mem_we, output, 1: RAM write strobe.
REQ-014 SHALL have port mem_re, output, 1: RAM read strobe.
REQ-015 SHALL have port mem_rdata, input, 32: RAM read data, valid on the cycle after mem_re.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, CAPTURE, DONE.
REQ-017 SHALL, in IDLE with any request high, select a winner and latch its we/addr/wdata, then go to ACCESS; with no request, SHALL stay in IDLE.
REQ-018 SHALL assert the winner's gnt from ACCESS through DONE inclusive; the loser's gnt SHALL stay 0.
REQ-019 SHALL, in ACCESS, drive mem_addr and mem_wdata from the latched values for exactly one cycle, with mem_we=1 for a write or mem_re=1 for a read.
REQ-020 SHALL go ACCESS->DONE for a write and ACCESS->CAPTURE->DONE for a read.
REQ-021 SHALL, in CAPTURE, register mem_rdata into the winner's rdata; the other port's rdata SHALL be unchanged.
REQ-022 SHALL, in DONE, pulse the winner's done for one cycle, then return to IDLE.
REQ-023 SHALL give write latency of 2 cycles and read latency of 3 cycles, from the edge that samples req in IDLE to done high.
REQ-024 SHALL hold each rdata until the next read completes on that port.
REQ-025 SHALL drive mem_addr, mem_wdata, mem_we and mem_re to 0 outside ACCESS.
REQ-026 SHALL complete a started transaction even if req drops mid-transaction; a write SHALL still occur.
REQ-027 SHALL start a new arbitration at the IDLE following DONE if req is still high, so back-to-back transactions cost one IDLE cycle.
REQ-028 SHALL ignore changes to we/addr/wdata after the latch in IDLE.

Reset
REQ-029 SHALL, on reset_n=0 (including mid-transaction), immediately force state to IDLE and all outputs to 0, including both rdata ports; no RAM strobe SHALL be issued.
REQ-030 SHALL, on reset, set the round-robin last-served pointer to "dbg" so the CPU wins the first tie.

Configuration
REQ-031 SHALL, when macro MEM_ARB_ROUND_ROBIN_EN is defined, resolve simultaneous requests in favour of the port not served last, updating the pointer in DONE.
REQ-032 SHALL, when MEM_ARB_ROUND_ROBIN_EN is undefined, always give the CPU fixed priority on ties, with no pointer state.

Verification
REQ-033 Bench SHALL cover: CPU write addr 0x010 data 0xDEADBEEF -> mem_we=1 for one cycle with mem_addr 0x010; cpu_done pulses 2 cycles after req sampled.
REQ-034 Bench SHALL cover: dbg read addr 0x010 with the RAM returning 0xDEADBEEF -> dbg_rdata=0xDEADBEEF, dbg_done 3 cycles after req sampled, cpu_rdata unchanged.
REQ-035 Bench SHALL cover: cpu_req and dbg_req held high together for 4 transactions -> order C,D,C,D with macro defined; C,C,C,C with dbg starved when undefined.
REQ-036 Bench SHALL cover: reset_n low during CAPTURE of a read -> all outputs 0 next sample, state IDLE, cpu_done never pulses.
REQ-037 Bench SHALL cover: cpu_req dropped during ACCESS of a write to 0x1FF -> write still issued and cpu_done still pulses once.
REQ-038 Bench SHALL cover: cpu_req held through DONE -> second transaction ACCESS begins exactly 2 cycles after the first done.
